// File: rtl/seven_seg_scan_if.sv
// Bus bundle for the multiplexed seven-segment scanner: display data and
// strobes going in, segment/anode pins and the frame marker coming out.
interface seven_seg_scan_if #(
    parameter int NUM_DIGITS = 4
) ();
    logic                      en;
    logic                      load;
    logic [4*NUM_DIGITS-1:0]   value;
    logic [NUM_DIGITS-1:0]     dp;
    logic [NUM_DIGITS-1:0]     blank;
    logic [6:0]                seg;
    logic                      dp_out;
    logic [NUM_DIGITS-1:0]     an;
    logic                      frame_start;

    modport master (
        output en, load, value, dp, blank,
        input  seg, dp_out, an, frame_start
    );

    modport slave (
        input  en, load, value, dp, blank,
        output seg, dp_out, an, frame_start
    );
endinterface

// File: rtl/seven_seg_scan.sv
// Multiplexed seven-segment display scanner. Data is double-buffered:
// loads land in a staged set and only reach the displayed set at the frame
// wrap, so a frame never shows a mix of old and new digits.
module seven_seg_scan #(
    parameter int NUM_DIGITS     = 4,
    parameter int REFRESH_DIV    = 50000,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    seven_seg_scan_if.slave   bus
);
    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int DIV_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0]      IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [DIV_W-1:0]      DIV_LAST = DIV_W'(REFRESH_DIV - 1);
    // Pin polarity masks, applied last so off/reset values invert too.
    localparam logic [6:0]            SEG_POL  = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
    localparam logic                  DP_POL   = (SEG_ACTIVE_LOW != 0);
    localparam logic [NUM_DIGITS-1:0] AN_POL   = (SEG_ACTIVE_LOW != 0) ?
                                                 {NUM_DIGITS{1'b1}} : {NUM_DIGITS{1'b0}};

    // Hex nibble to active-high segments, bit 0 = a ... bit 6 = g.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        case (nib)
            4'h0:    s = 7'h3F;
            4'h1:    s = 7'h06;
            4'h2:    s = 7'h5B;
            4'h3:    s = 7'h4F;
            4'h4:    s = 7'h66;
            4'h5:    s = 7'h6D;
            4'h6:    s = 7'h7D;
            4'h7:    s = 7'h07;
            4'h8:    s = 7'h7F;
            4'h9:    s = 7'h6F;
            4'hA:    s = 7'h77;
            4'hB:    s = 7'h7C;
            4'hC:    s = 7'h39;
            4'hD:    s = 7'h5E;
            4'hE:    s = 7'h79;
            4'hF:    s = 7'h71;
            default: s = 7'h00;
        endcase
        return s;
    endfunction

    logic [DIV_W-1:0]        div_cnt_r, div_nxt_s;
    logic [IDX_W-1:0]        idx_r, idx_nxt_s;
    logic                    wrap_s;
    logic                    pending_r;
    logic [4*NUM_DIGITS-1:0] stg_value_r, disp_value_r;
    logic [NUM_DIGITS-1:0]   stg_dp_r, disp_dp_r;
    logic [NUM_DIGITS-1:0]   stg_blank_r, disp_blank_r;
    logic [3:0]              digit_s;
    logic [6:0]              seg_s;
    logic                    dp_s;
    logic [NUM_DIGITS-1:0]   an_s;
    logic [6:0]              seg_r;
    logic                    dp_out_r;
    logic [NUM_DIGITS-1:0]   an_r;
    logic                    frame_start_r;

    // Scan position update: divider terminal count advances the digit index.
    always_comb begin
        div_nxt_s = div_cnt_r;
        idx_nxt_s = idx_r;
        wrap_s    = 1'b0;
        if (bus.en) begin
            if (div_cnt_r == DIV_LAST) begin
                div_nxt_s = {DIV_W{1'b0}};
                if (idx_r == IDX_LAST) begin
                    idx_nxt_s = {IDX_W{1'b0}};
                    wrap_s    = 1'b1;
                end else begin
                    idx_nxt_s = idx_r + IDX_W'(1);
                end
            end else begin
                div_nxt_s = div_cnt_r + DIV_W'(1);
            end
        end else begin
            div_nxt_s = div_cnt_r;
            idx_nxt_s = idx_r;
        end
    end

    // Scan position register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= {DIV_W{1'b0}};
            idx_r     <= {IDX_W{1'b0}};
        end else begin
            div_cnt_r <= div_nxt_s;
            idx_r     <= idx_nxt_s;
        end
    end

    // Staged/displayed data sets; displayed only changes on the wrap cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending_r    <= 1'b0;
            stg_value_r  <= {(4*NUM_DIGITS){1'b0}};
            stg_dp_r     <= {NUM_DIGITS{1'b0}};
            stg_blank_r  <= {NUM_DIGITS{1'b0}};
            disp_value_r <= {(4*NUM_DIGITS){1'b0}};
            disp_dp_r    <= {NUM_DIGITS{1'b0}};
            disp_blank_r <= {NUM_DIGITS{1'b0}};
        end else if (bus.load && wrap_s) begin
            stg_value_r  <= bus.value;
            stg_dp_r     <= bus.dp;
            stg_blank_r  <= bus.blank;
            disp_value_r <= bus.value;
            disp_dp_r    <= bus.dp;
            disp_blank_r <= bus.blank;
            pending_r    <= 1'b0;
        end else if (wrap_s && pending_r) begin
            disp_value_r <= stg_value_r;
            disp_dp_r    <= stg_dp_r;
            disp_blank_r <= stg_blank_r;
            pending_r    <= 1'b0;
        end else if (bus.load) begin
            stg_value_r  <= bus.value;
            stg_dp_r     <= bus.dp;
            stg_blank_r  <= bus.blank;
            pending_r    <= 1'b1;
        end
    end

    // Pin values for the current digit: disable, blanking and anti-ghost gap.
    always_comb begin
        digit_s = disp_value_r[{idx_r, 2'b00} +: 4];
        seg_s   = 7'h00;
        dp_s    = 1'b0;
        an_s    = {NUM_DIGITS{1'b0}};
        if (bus.en) begin
            for (int k = 0; k < NUM_DIGITS; k++) begin
                an_s[k] = (idx_r == IDX_W'(k)) && (div_cnt_r != DIV_LAST);
            end
            if (disp_blank_r[idx_r]) begin
                seg_s = 7'h00;
                dp_s  = 1'b0;
            end else begin
                seg_s = hex_to_seg(digit_s);
                dp_s  = disp_dp_r[idx_r];
            end
        end else begin
            seg_s = 7'h00;
            dp_s  = 1'b0;
            an_s  = {NUM_DIGITS{1'b0}};
        end
    end

    // Output registers with pin polarity applied.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r         <= SEG_POL;
            dp_out_r      <= DP_POL;
            an_r          <= AN_POL;
            frame_start_r <= 1'b0;
        end else begin
            seg_r         <= seg_s ^ SEG_POL;
            dp_out_r      <= dp_s ^ DP_POL;
            an_r          <= an_s ^ AN_POL;
            frame_start_r <= wrap_s;
        end
    end

    assign bus.seg         = seg_r;
    assign bus.dp_out      = dp_out_r;
    assign bus.an          = an_r;
    assign bus.frame_start = frame_start_r;
endmodule
